// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute unit holding the GPR file, the SGPR
// (upper half of multiply results) and the {sign, zero, carry, overflow} flags.
// Single-cycle ALU/logic ops go through EXEC; MUL is an iterative shift-add.
//
// Ports:
//   clk, sys_rst         clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  instruction handshake; in_ready high only in IDLE
//   op, rdst, rsrc1,     instruction fields: opcode, destination, sources,
//   rsrc2, imm_mode, imm immediate select and zero-extended immediate
//   done, illegal        one-cycle retire pulse; illegal pulses with done
//   busy                 high while in EXEC or MUL
//   flags                {sign, zero, carry, overflow}
//   sgpr                 current special register
//   dbg_raddr/dbg_rdata  combinational GPR debug read port
module alu_exec_unit #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 32,
    parameter int unsigned RAW  = 5,
    parameter int unsigned IMW  = 16
) (
    input  logic           clk,
    input  logic           sys_rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4:0]     op,
    input  logic [RAW-1:0] rdst,
    input  logic [RAW-1:0] rsrc1,
    input  logic [RAW-1:0] rsrc2,
    input  logic           imm_mode,
    input  logic [IMW-1:0] imm,
    output logic           done,
    output logic           illegal,
    output logic           busy,
    output logic [3:0]     flags,
    output logic [DW-1:0]  sgpr,
    input  logic [RAW-1:0] dbg_raddr,
    output logic [DW-1:0]  dbg_rdata
);

    localparam int unsigned CW = $clog2(DW + 1);

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     op_q, op_d;
    logic [RAW-1:0] rdst_q, rdst_d;
    logic           imm_mode_q, imm_mode_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [DW-1:0]  hi_q, hi_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  gpr_q [NREG];
    logic [DW-1:0]  gpr_d [NREG];
    logic [DW-1:0]  sgpr_q, sgpr_d;
    logic [3:0]     flags_q, flags_d;
    logic           done_q, done_d;
    logic           illegal_q, illegal_d;
    logic           busy_q, busy_d;
    logic           in_ready_q, in_ready_d;

    logic [DW:0]    sum_w;
    logic [DW:0]    diff_w;
    logic [DW:0]    mac_w;
    logic [DW-1:0]  res_w;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rdst_d     = rdst_q;
        imm_mode_d = imm_mode_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        cnt_d      = cnt_q;
        gpr_d      = gpr_q;
        sgpr_d     = sgpr_q;
        flags_d    = flags_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        res_w      = '0;

        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        // Top bit of the extended difference is the unsigned borrow.
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        // Shift-add step: b_q holds the remaining multiplier bits (low half of P).
        mac_w  = {1'b0, hi_q} + {1'b0, a_q & {DW{b_q[0]}}};

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = op;
                    rdst_d     = rdst;
                    imm_mode_d = imm_mode;
                    a_d        = gpr_q[rsrc1];
                    b_d        = imm_mode ? DW'(imm) : gpr_q[rsrc2];
                    hi_d       = '0;
                    cnt_d      = '0;
                    state_d    = (op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_MOVSGPR: gpr_d[rdst_q] = sgpr_q;
                    OP_MOV:     gpr_d[rdst_q] = imm_mode_q ? b_q : a_q;
                    OP_ADD: begin
                        res_w         = sum_w[DW-1:0];
                        gpr_d[rdst_q] = res_w;
                        flags_d = {res_w[DW-1], (res_w == '0), sum_w[DW],
                                   (a_q[DW-1] == b_q[DW-1]) && (res_w[DW-1] != a_q[DW-1])};
                    end
                    OP_SUB: begin
                        res_w         = diff_w[DW-1:0];
                        gpr_d[rdst_q] = res_w;
                        flags_d = {res_w[DW-1], (res_w == '0), diff_w[DW],
                                   (a_q[DW-1] != b_q[DW-1]) && (res_w[DW-1] != a_q[DW-1])};
                    end
                    OP_OR, OP_AND, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOT: begin
                        case (op_q)
                            OP_OR:   res_w = a_q | b_q;
                            OP_AND:  res_w = a_q & b_q;
                            OP_XOR:  res_w = a_q ^ b_q;
                            OP_XNOR: res_w = ~(a_q ^ b_q);
                            OP_NAND: res_w = ~(a_q & b_q);
                            OP_NOR:  res_w = ~(a_q | b_q);
                            default: res_w = ~a_q;
                        endcase
                        gpr_d[rdst_q] = res_w;
                        flags_d       = {res_w[DW-1], (res_w == '0), 2'b00};
                    end
                    // MUL never reaches EXEC, so only opcodes 12..31 land here.
                    default: illegal_d = 1'b1;
                endcase
            end

            S_MUL: begin
                // DW shift-add iterations, then one writeback cycle.
                if (cnt_q == CW'(DW)) begin
                    gpr_d[rdst_q] = b_q;
                    sgpr_d        = hi_q;
                    flags_d       = {hi_q[DW-1], ({hi_q, b_q} == '0), 2'b00};
                    state_d       = S_IDLE;
                    done_d        = 1'b1;
                end else begin
                    hi_d  = mac_w[DW:1];
                    b_d   = {mac_w[0], b_q[DW-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rdst_q     <= '0;
            imm_mode_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            cnt_q      <= '0;
            sgpr_q     <= '0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rdst_q     <= rdst_d;
            imm_mode_q <= imm_mode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            sgpr_q     <= sgpr_d;
            flags_q    <= flags_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign busy      = busy_q;
    assign flags     = flags_q;
    assign sgpr      = sgpr_q;
    assign dbg_rdata = gpr_q[dbg_raddr];

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, handshaked execute unit for the simple processor. It holds the general-purpose register file (GPR), the special register (SGPR) for the upper half of multiply results, and the sign/zero/carry/overflow flags.
- Single-cycle ALU/logic ops retire in fixed latency. MUL runs as an iterative shift-add sequence.
- Instruction fields arrive from the decode stage on a valid/ready handshake. A debug read port exposes the GPRs to the bench.

Parameters:
- DW, 16, data/register width in bits (>=8).
- NREG, 32, number of GPRs (power of two).
- RAW, 5, register address width, log2(NREG).
- IMW, 16, immediate width (IMW <= DW); zero-extended to DW.

Ports:
- clk  in  1  clock, rising edge.
- sys_rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  5  opcode: 0 movsgpr, 1 mov, 2 add, 3 sub, 4 mul, 5 or, 6 and, 7 xor, 8 xnor, 9 nand, 10 nor, 11 not.
- rdst  in  RAW  destination register.
- rsrc1  in  RAW  source 1.
- rsrc2  in  RAW  source 2 (ignored when imm_mode=1).
- imm_mode  in  1  1: operand 2 = immediate.
- imm  in  IMW  immediate.
- done  out  1  one-cycle retire pulse.
- illegal  out  1  one-cycle pulse with done for opcodes 12..31.
- busy  out  1  high in EXEC/MUL.
- flags  out  4  {sign, zero, carry, overflow}.
- sgpr  out  DW  current SGPR.
- dbg_raddr  in  RAW  debug read address.
- dbg_rdata  out  DW  GPR[dbg_raddr], combinational.

Behaviour:
- Reset (async, any state, including mid-MUL):
  - State goes to IDLE; all GPRs, SGPR and flags are cleared to 0.
  - done=0, illegal=0, busy=0, in_ready=1 once reset deasserts.
  - Any in-flight instruction is discarded with no writeback and no done.
- States: IDLE, EXEC, MUL.
- Accept: an instruction is accepted when in_valid && in_ready at a clock edge.
  - At that edge the unit latches op, rdst, A=GPR[rsrc1], B = imm_mode ? zero-extended imm : GPR[rsrc2].
  - in_valid is ignored while in_ready=0.
- Transitions:
  - IDLE->MUL on op=4; IDLE->EXEC on any other opcode.
  - EXEC->IDLE at the next edge.
  - MUL->IDLE after DW iterations.
- EXEC writeback edge (one cycle after accept):
  - Writes GPR[rdst] and flags; done is registered high for the following cycle.
  - Accept-to-done latency is 2 cycles.
- MUL:
  - Unsigned shift-add, one multiplier bit per cycle over DW cycles.
  - The final edge writes GPR[rdst] = P[DW-1:0] and SGPR = P[2DW-1:DW].
  - done follows, so latency is DW+2 cycles (18 at default).
- Back-to-back: the state is IDLE during the done cycle, so in_ready=1 and a new instruction may be accepted in that cycle. No forwarding is needed because writes complete before the next operand read.
- Operations:
  - movsgpr: rdst=SGPR.
  - mov: rdst = imm_mode ? imm : A.
  - add: A+B; sub: A-B.
  - or/and/xor/xnor/nand/nor: bitwise on A and B.
  - not: ~A.
- Flags:
  - add: sign=R[DW-1]; zero=(R==0); carry=carry-out of DW-bit add; overflow=(A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - sub: carry=borrow (A<B unsigned); overflow=(A[msb]!=B[msb]) && (R[msb]!=A[msb]); sign and zero as for add.
  - mul: sign=P[2DW-1]; zero=(P==0); carry=0; overflow=0.
  - logic ops: sign and zero from R; carry=0; overflow=0.
  - mov, movsgpr: flags unchanged.
- Illegal opcodes (12..31): take the EXEC path with no GPR, SGPR or flag change; done and illegal pulse together.
- Same-register use is legal: rdst may equal rsrc1 or rsrc2. Operands are latched at accept, so writeback never corrupts them.
- Writing any GPR, including r0, is legal; there is no hardwired-zero register.

Test Plan:
- Reset; MOVI r2=2; ADDI r0=r2+4 -> r0=0x0006, flags=0000, done exactly 2 cycles after accept, in_ready=1 in the done cycle.
- MOVI r1=0x0100, MOVI r3=0x0300; MUL r4=r1*r3 -> r4=0x0000, sgpr=0x0003, flags=0000, done 18 cycles after accept, busy high throughout; MOVSGPR r5 -> r5=0x0003.
- MOVI r0=0x8000, r1=0x8002; ADD r2=r0+r1 -> r2=0x0002, sign=0, zero=0, carry=1, overflow=1. Then ADD r2=r6+r7 with both 0 -> zero=1, others 0.
- MOVI r0=0, r1=1; SUB r2=r0-r1 -> r2=0xFFFF, sign=1, carry=1, overflow=0. NOT r3=r2 -> r3=0x0000, zero=1.
- Start MUL, assert sys_rst (asynchronously, mid-cycle) 5 cycles in -> no done, GPRs/SGPR/flags read 0, in_ready=1 after release.
- op=13 with in_valid held through busy -> exactly one accept, done and illegal pulse together, no register or flag change.
